// File: rtl/exec_unit.sv
// Integer execute stage: arithmetic/logical/shift/immediate result, branch-target or
// data-memory address, and branch-condition flag. All outputs are registered, so a result
// appears one cycle after its inputs. A synchronous active-low reset clears every output.
module exec_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] rs1_d,
  input  logic [31:0] rs2i_d,
  input  logic [31:0] imm_d,
  input  logic [31:0] pc_v,
  input  logic [31:0] off_v,
  input  logic [3:0]  opa_a,
  input  logic [3:0]  op_s,
  input  logic [2:0]  op_l,
  input  logic [1:0]  sel_r,
  input  logic [2:0]  bra_c,
  input  logic        b_rs1_pc,
  output logic [31:0] res_d_op,
  output logic [31:0] res_brt_dma,
  output logic        res_bra
);

  // Arithmetic op codes
  localparam logic [3:0] OPA_ADD   = 4'b0000;
  localparam logic [3:0] OPA_SUB   = 4'b1000;
  localparam logic [3:0] OPA_SLT   = 4'b0010;
  localparam logic [3:0] OPA_SLTU  = 4'b0011;
  localparam logic [3:0] OPA_AUIPC = 4'b0101;
  localparam logic [3:0] OPA_LINK  = 4'b0110;

  // Logical op codes
  localparam logic [2:0] OPL_XOR = 3'b100;
  localparam logic [2:0] OPL_OR  = 3'b110;
  localparam logic [2:0] OPL_AND = 3'b111;

  // Shift op codes
  localparam logic [3:0] OPS_SLL = 4'b0001;
  localparam logic [3:0] OPS_SRL = 4'b0101;
  localparam logic [3:0] OPS_SRA = 4'b1101;

  // Result source select
  localparam logic [1:0] SEL_ARITH = 2'b00;
  localparam logic [1:0] SEL_LOGIC = 2'b01;
  localparam logic [1:0] SEL_SHIFT = 2'b10;
  localparam logic [1:0] SEL_IMM   = 2'b11;

  // Branch condition codes
  localparam logic [2:0] BRA_EQ     = 3'b000;
  localparam logic [2:0] BRA_NE     = 3'b001;
  localparam logic [2:0] BRA_NEVER  = 3'b010;
  localparam logic [2:0] BRA_ALWAYS = 3'b011;
  localparam logic [2:0] BRA_LT     = 3'b100;
  localparam logic [2:0] BRA_GE     = 3'b101;
  localparam logic [2:0] BRA_LTU    = 3'b110;
  localparam logic [2:0] BRA_GEU    = 3'b111;

  logic [31:0] arith_res;
  logic [31:0] logic_res;
  logic [31:0] shift_res;
  logic [4:0]  shamt;
  logic        lt_s;
  logic        lt_u;
  logic        eq;

  logic [31:0] res_d_op_d,    res_d_op_q;
  logic [31:0] res_brt_dma_d, res_brt_dma_q;
  logic        res_bra_d,     res_bra_q;

  // Shared comparisons used by both SLT/SLTU and the branch unit
  assign lt_s  = $signed(rs1_d) < $signed(rs2i_d);
  assign lt_u  = rs1_d < rs2i_d;
  assign eq    = rs1_d == rs2i_d;
  assign shamt = rs2i_d[4:0];

  // Arithmetic unit; all sums wrap modulo 2^32
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    arith_res = '0;
    case (opa_a)
      OPA_ADD:   arith_res = rs1_d + rs2i_d;
      OPA_SUB:   arith_res = rs1_d - rs2i_d;
      OPA_SLT:   arith_res = {31'd0, lt_s};
      OPA_SLTU:  arith_res = {31'd0, lt_u};
      OPA_AUIPC: arith_res = pc_v + imm_d;
      OPA_LINK:  arith_res = pc_v + 32'd4;
      default:   arith_res = '0;
    endcase
  end

  // Logical unit
  always_comb begin
    logic_res = '0;
    case (op_l)
      OPL_XOR: logic_res = rs1_d ^ rs2i_d;
      OPL_OR:  logic_res = rs1_d | rs2i_d;
      OPL_AND: logic_res = rs1_d & rs2i_d;
      default: logic_res = '0;
    endcase
  end

  // Shift unit; only the low five bits of rs2i_d form the amount
  always_comb begin
    shift_res = '0;
    case (op_s)
      OPS_SLL: shift_res = rs1_d << shamt;
      OPS_SRL: shift_res = rs1_d >> shamt;
      OPS_SRA: shift_res = $unsigned($signed(rs1_d) >>> shamt);
      default: shift_res = '0;
    endcase
  end

  // Next-state values for the three output registers
  always_comb begin
    res_d_op_d = '0;
    case (sel_r)
      SEL_ARITH: res_d_op_d = arith_res;
      SEL_LOGIC: res_d_op_d = logic_res;
      SEL_SHIFT: res_d_op_d = shift_res;
      SEL_IMM:   res_d_op_d = imm_d;
      default:   res_d_op_d = '0;
    endcase

    // No LSB masking here; JALR alignment is handled downstream
    res_brt_dma_d = (b_rs1_pc ? pc_v : rs1_d) + off_v;

    res_bra_d = 1'b0;
    case (bra_c)
      BRA_EQ:     res_bra_d = eq;
      BRA_NE:     res_bra_d = ~eq;
      BRA_NEVER:  res_bra_d = 1'b0;
      BRA_ALWAYS: res_bra_d = 1'b1;
      BRA_LT:     res_bra_d = lt_s;
      BRA_GE:     res_bra_d = ~lt_s;
      BRA_LTU:    res_bra_d = lt_u;
      BRA_GEU:    res_bra_d = ~lt_u;
      default:    res_bra_d = 1'b0;
    endcase
  end

  // Output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    // NOTE: state is written with non-blocking assignments so every flop samples the
    // pre-edge values regardless of statement order.
    if (!rst_n) begin
      res_d_op_q    <= '0;
      res_brt_dma_q <= '0;
      res_bra_q     <= 1'b0;
    end else begin
      res_d_op_q    <= res_d_op_d;
      res_brt_dma_q <= res_brt_dma_d;
      res_bra_q     <= res_bra_d;
    end
  end

  assign res_d_op    = res_d_op_q;
  assign res_brt_dma = res_brt_dma_q;
  assign res_bra     = res_bra_q;

endmodule

// File: tb/tb_exec_unit.sv
// Directed testbench for exec_unit: drives hand-built vectors one clock at a time and
// compares the registered outputs one edge later against hand-computed values.
module tb_exec_unit;

  logic        clk;
  logic        rst_n;
  logic [31:0] rs1_d;
  logic [31:0] rs2i_d;
  logic [31:0] imm_d;
  logic [31:0] pc_v;
  logic [31:0] off_v;
  logic [3:0]  opa_a;
  logic [3:0]  op_s;
  logic [2:0]  op_l;
  logic [1:0]  sel_r;
  logic [2:0]  bra_c;
  logic        b_rs1_pc;
  logic [31:0] res_d_op;
  logic [31:0] res_brt_dma;
  logic        res_bra;

  int n_cmp = 0;
  int n_err = 0;

  exec_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rs1_d       (rs1_d),
    .rs2i_d      (rs2i_d),
    .imm_d       (imm_d),
    .pc_v        (pc_v),
    .off_v       (off_v),
    .opa_a       (opa_a),
    .op_s        (op_s),
    .op_l        (op_l),
    .sel_r       (sel_r),
    .bra_c       (bra_c),
    .b_rs1_pc    (b_rs1_pc),
    .res_d_op    (res_d_op),
    .res_brt_dma (res_brt_dma),
    .res_bra     (res_bra)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle past it before sampling
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset held for two cycles with nonzero inputs
    rst_n = 1'b0;
    rs1_d = 32'h0000_00FF; rs2i_d = 32'h0000_1001; imm_d = 32'hDEAD_B000;
    pc_v = 32'h0000_2000;  off_v = 32'h0000_0010;
    opa_a = 4'b0000; op_s = 4'b0001; op_l = 3'b111; sel_r = 2'b00;
    bra_c = 3'b011; b_rs1_pc = 1'b1;
    tick();
    check("rst1_d_op", res_d_op, 32'h0);
    check("rst1_brt", res_brt_dma, 32'h0);
    check("rst1_bra", {31'd0, res_bra}, 32'h0);
    tick();
    check("rst2_d_op", res_d_op, 32'h0);
    check("rst2_bra", {31'd0, res_bra}, 32'h0);

    // Release: ADD result visible after the next edge
    rst_n = 1'b1;
    tick();
    check("add", res_d_op, 32'h0000_1100);
    check("addr_pc_rel", res_brt_dma, 32'h0000_2010);
    check("always_rel", {31'd0, res_bra}, 32'h1);

    opa_a = 4'b1000;
    tick();
    check("sub", res_d_op, 32'hFFFF_F0FE);

    opa_a = 4'b0000;
    tick();
    check("add_again", res_d_op, 32'h0000_1100);

    // One-cycle latency: new inputs must not show before the edge
    opa_a = 4'b1000;
    #2;
    check("latency_hold", res_d_op, 32'h0000_1100);
    tick();
    check("latency_sub", res_d_op, 32'hFFFF_F0FE);

    // Shifts on the most negative value
    rs1_d = 32'h8000_0000; rs2i_d = 32'h0000_0004; sel_r = 2'b10;
    op_s = 4'b1101; tick(); check("sra", res_d_op, 32'hF800_0000);
    op_s = 4'b0101; tick(); check("srl", res_d_op, 32'h0800_0000);
    op_s = 4'b0001; tick(); check("sll", res_d_op, 32'h0000_0000);
    rs2i_d = 32'hFFFF_FFE4;  // upper bits ignored, amount = 4
    op_s = 4'b1101; tick(); check("sra_upper_ign", res_d_op, 32'hF800_0000);
    rs1_d = 32'h8765_4321; rs2i_d = 32'h0000_0020;  // amount = 0
    tick(); check("sra_by0", res_d_op, 32'h8765_4321);
    op_s = 4'b0011; tick(); check("shift_bad_op", res_d_op, 32'h0);

    // Branch conditions and set-less-than with -1 vs 1
    rs1_d = 32'hFFFF_FFFF; rs2i_d = 32'h0000_0001; sel_r = 2'b00;
    opa_a = 4'b0010; bra_c = 3'b100; tick();
    check("slt", res_d_op, 32'h1);
    check("br_lt", {31'd0, res_bra}, 32'h1);
    opa_a = 4'b0011; bra_c = 3'b110; tick();
    check("sltu", res_d_op, 32'h0);
    check("br_ltu", {31'd0, res_bra}, 32'h0);
    bra_c = 3'b000; tick(); check("br_eq", {31'd0, res_bra}, 32'h0);
    bra_c = 3'b001; tick(); check("br_ne", {31'd0, res_bra}, 32'h1);
    bra_c = 3'b010; tick(); check("br_never", {31'd0, res_bra}, 32'h0);
    bra_c = 3'b011; tick(); check("br_always", {31'd0, res_bra}, 32'h1);
    bra_c = 3'b101; tick(); check("br_ge", {31'd0, res_bra}, 32'h0);
    bra_c = 3'b111; tick(); check("br_geu", {31'd0, res_bra}, 32'h1);

    // Signed boundary: 0x80000000 < 0x7FFFFFFF signed, not unsigned
    rs1_d = 32'h8000_0000; rs2i_d = 32'h7FFF_FFFF;
    bra_c = 3'b100; tick(); check("br_lt_min", {31'd0, res_bra}, 32'h1);
    bra_c = 3'b111; tick(); check("br_geu_min", {31'd0, res_bra}, 32'h1);

    // EQ with both operands zero
    rs1_d = 32'h0; rs2i_d = 32'h0; bra_c = 3'b000;
    tick(); check("br_eq_zero", {31'd0, res_bra}, 32'h1);

    // Overflow wrap on ADD
    rs1_d = 32'h7FFF_FFFF; rs2i_d = 32'h0000_0001; opa_a = 4'b0000;
    tick(); check("add_wrap", res_d_op, 32'h8000_0000);

    // AUIPC, LINK, unused arithmetic code
    pc_v = 32'h0000_4000; imm_d = 32'h1234_5000;
    opa_a = 4'b0101; tick(); check("auipc", res_d_op, 32'h1234_9000);
    opa_a = 4'b0110; tick(); check("link", res_d_op, 32'h0000_4004);
    opa_a = 4'b1111; tick(); check("arith_bad_op", res_d_op, 32'h0);

    // Address generation
    rs1_d = 32'h0000_1000; pc_v = 32'h0000_2000; off_v = 32'hFFFF_FFFC;
    b_rs1_pc = 1'b0; tick(); check("addr_rs1", res_brt_dma, 32'h0000_0FFC);
    b_rs1_pc = 1'b1; tick(); check("addr_pc", res_brt_dma, 32'h0000_1FFC);

    // Logical unit and LUI pass-through
    rs1_d = 32'hF0F0_F0F0; rs2i_d = 32'h0FF0_0FF0; sel_r = 2'b01;
    op_l = 3'b100; tick(); check("xor", res_d_op, 32'hFF00_FF00);
    op_l = 3'b110; tick(); check("or",  res_d_op, 32'hFFF0_FFF0);
    op_l = 3'b111; tick(); check("and", res_d_op, 32'h00F0_00F0);
    op_l = 3'b000; tick(); check("logic_bad_op", res_d_op, 32'h0);
    sel_r = 2'b11; imm_d = 32'h1234_5000;
    tick(); check("lui", res_d_op, 32'h1234_5000);

    // Mid-sequence reset clears all outputs on the next edge
    bra_c = 3'b011;
    tick(); check("pre_rst_bra", {31'd0, res_bra}, 32'h1);
    rst_n = 1'b0;
    tick();
    check("midrst_d_op", res_d_op, 32'h0);
    check("midrst_brt", res_brt_dma, 32'h0);
    check("midrst_bra", {31'd0, res_bra}, 32'h0);
    rst_n = 1'b1;
    tick(); check("post_rst_lui", res_d_op, 32'h1234_5000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
